// File: rtl/sal_bank_timing_cntr_if.sv
// Bus for sal_bank_timing_cntr: per-bank load, broadcast load, hold, and the
// zero flags. The loads and hold are single-cycle strobes with no back-pressure:
// the counter block has no ready, so a strobe is taken on every clk edge where it is high.
// The slave modport is for the counter block and the master modport is for the scheduler.
// Optional signal: is_zero_n_o exists only when SAL_TIMING_CNTR_EARLY_EN is defined.
interface sal_bank_timing_cntr_if #(
  parameter int CNTR_WIDTH = 5,
  parameter int NUM_BANKS  = 4
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                  load_valid_i;
  logic [BANK_W-1:0]     load_bank_i;
  logic [CNTR_WIDTH-1:0] load_value_i;
  logic                  all_load_i;
  logic [CNTR_WIDTH-1:0] all_value_i;
  logic                  hold_i;
  logic [NUM_BANKS-1:0]  is_zero_o;
  logic                  all_zero_o;
`ifdef SAL_TIMING_CNTR_EARLY_EN
  logic [NUM_BANKS-1:0]  is_zero_n_o;

  modport master (
    output load_valid_i, load_bank_i, load_value_i,
    output all_load_i, all_value_i, hold_i,
    input  is_zero_o, all_zero_o, is_zero_n_o
  );

  modport slave (
    input  load_valid_i, load_bank_i, load_value_i,
    input  all_load_i, all_value_i, hold_i,
    output is_zero_o, all_zero_o, is_zero_n_o
  );
`else
  modport master (
    output load_valid_i, load_bank_i, load_value_i,
    output all_load_i, all_value_i, hold_i,
    input  is_zero_o, all_zero_o
  );

  modport slave (
    input  load_valid_i, load_bank_i, load_value_i,
    input  all_load_i, all_value_i, hold_i,
    output is_zero_o, all_zero_o
  );
`endif
endinterface

// File: rtl/sal_bank_timing_cntr.sv
// sal_bank_timing_cntr: one saturating down-counter per DRAM bank. A bank may
// take its next constrained command only while its zero flag is high.
// Loads merge by maximum, so a short constraint never cuts a longer pending one.
// Optional feature macro: SAL_TIMING_CNTR_EARLY_EN adds the combinational
// next-cycle zero flags (is_zero_n_o), which form a critical path.
module sal_bank_timing_cntr #(
  parameter int CNTR_WIDTH = 5,
  parameter int NUM_BANKS  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sal_bank_timing_cntr_if.slave   bus
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [NUM_BANKS-1:0][CNTR_WIDTH-1:0] r_cntr;
  logic [NUM_BANKS-1:0][CNTR_WIDTH-1:0] w_dec;
  logic [NUM_BANKS-1:0][CNTR_WIDTH-1:0] w_cand_p;
  logic [NUM_BANKS-1:0][CNTR_WIDTH-1:0] w_cand_a;
  logic [NUM_BANKS-1:0][CNTR_WIDTH-1:0] w_max_pa;
  logic [NUM_BANKS-1:0][CNTR_WIDTH-1:0] w_cntr_n;
  logic [NUM_BANKS-1:0]                 w_zero_n;
  logic [NUM_BANKS-1:0]                 r_is_zero;
  logic                                 r_all_zero;

  // Next count per bank: saturating decrement (frozen by hold), then max-merge
  // with the per-bank and broadcast candidates. A bank index past NUM_BANKS
  // matches no bank, so it is dropped.
  always_comb begin
    w_dec    = '0;
    w_cand_p = '0;
    w_cand_a = '0;
    w_max_pa = '0;
    w_cntr_n = '0;
    w_zero_n = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_dec[b]    = ((r_cntr[b] != '0) && !bus.hold_i) ?
                    (r_cntr[b] - CNTR_WIDTH'(1)) : r_cntr[b];
      w_cand_p[b] = (bus.load_valid_i && (bus.load_bank_i == BANK_W'(b))) ?
                    bus.load_value_i : '0;
      w_cand_a[b] = bus.all_load_i ? bus.all_value_i : '0;
      w_max_pa[b] = (w_cand_p[b] > w_cand_a[b]) ? w_cand_p[b] : w_cand_a[b];
      w_cntr_n[b] = (w_max_pa[b] > w_dec[b]) ? w_max_pa[b] : w_dec[b];
      w_zero_n[b] = (w_cntr_n[b] == '0);
    end
  end

  // Counter state and registered zero flags. The flags are registered from
  // the next count, so they line up with the counters with no input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cntr     <= '0;
      r_is_zero  <= '1;
      r_all_zero <= 1'b1;
    end else begin
      r_cntr     <= w_cntr_n;
      r_is_zero  <= w_zero_n;
      r_all_zero <= &w_zero_n;
    end
  end

  assign bus.is_zero_o  = r_is_zero;
  assign bus.all_zero_o = r_all_zero;

`ifdef SAL_TIMING_CNTR_EARLY_EN
  // Early flags: the zero state the registers will take at the next edge.
  // They are forced to all-ones while reset is asserted.
  assign bus.is_zero_n_o = rst_n ? w_zero_n : '1;
`endif

endmodule

// File: tb/tb_sal_bank_timing_cntr.sv
// Testbench for sal_bank_timing_cntr. It uses a 4-bank instance for the main
// checks and a 3-bank instance for the out-of-range bank index.
// Optional macro: SAL_TIMING_CNTR_EARLY_EN also checks is_zero_n_o.
module tb_sal_bank_timing_cntr;
  localparam int CW = 5;
  localparam int NB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sal_bank_timing_cntr_if #(.CNTR_WIDTH(CW), .NUM_BANKS(NB)) bus4 ();
  sal_bank_timing_cntr_if #(.CNTR_WIDTH(CW), .NUM_BANKS(3))  bus3 ();

  sal_bank_timing_cntr #(.CNTR_WIDTH(CW), .NUM_BANKS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  sal_bank_timing_cntr #(.CNTR_WIDTH(CW), .NUM_BANKS(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] m_cntr [NB];
  logic [CW-1:0] m_next [NB];
  logic [NB:0]   exp_q [$];
  logic [NB:0]   exp_v;
  logic [NB:0]   obs_v;
`ifdef SAL_TIMING_CNTR_EARLY_EN
  logic [NB-1:0] early_exp_q [$];
  logic [NB-1:0] early_obs_q [$];
`endif

  // ---------------- driver ----------------
  // Drives one cycle of stimulus on bus4 (called just after a rising edge),
  // pushes the expected {all_zero, is_zero} for the following cycle, then
  // advances to 1 ns after the next rising edge.
  task automatic step(input logic rst, input logic lv, input int bank,
                      input int val, input logic al, input int av,
                      input logic hold);
    logic [CW-1:0] dec, cp, ca, mx;
    logic [NB-1:0] z;
    rst_n              = rst;
    bus4.load_valid_i  = lv;
    bus4.load_bank_i   = 2'(bank);
    bus4.load_value_i  = CW'(val);
    bus4.all_load_i    = al;
    bus4.all_value_i   = CW'(av);
    bus4.hold_i        = hold;
    for (int b = 0; b < NB; b++) begin
      dec = (m_cntr[b] != 0 && !hold) ? m_cntr[b] - CW'(1) : m_cntr[b];
      cp  = (lv && bank == b) ? CW'(val) : '0;
      ca  = al ? CW'(av) : '0;
      mx  = (cp > ca) ? cp : ca;
      m_next[b] = !rst ? '0 : ((mx > dec) ? mx : dec);
      z[b] = (m_next[b] == 0);
    end
    exp_q.push_back({&z, z});
`ifdef SAL_TIMING_CNTR_EARLY_EN
    #2;
    early_obs_q.push_back(bus4.is_zero_n_o);
    early_exp_q.push_back(z);
`endif
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) m_cntr[b] = m_next[b];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0, 1:    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        2:       step(1'b1, 1'b0, 0, 0, 1'b1, 9, 1'b0);
        3:       step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        4:       step(1'b0, 1'b1, 0, 20, 1'b1, 25, 1'b1);
        default: step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      endcase
      exp_v = exp_q.pop_front();
      obs_v = {bus4.all_zero_o, bus4.is_zero_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b expected=%b", c, obs_v, exp_v);
      end
      if (c == 4) begin
        checks++;
        if (bus4.is_zero_o !== 4'b1111 || bus4.all_zero_o !== 1'b1) begin
          failures++;
          $display("FAIL reset_mid_count got=%b/%b expected=1111/1",
                   bus4.is_zero_o, bus4.all_zero_o);
        end
      end
    end
  endtask

  task automatic test_countdown();
    int low2 = 0;
    int low_other = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) step(1'b1, 1'b1, 2, 3, 1'b0, 0, 1'b0);
      else        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      exp_v = exp_q.pop_front();
      obs_v = {bus4.all_zero_o, bus4.is_zero_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL countdown cyc=%0d got=%b expected=%b", c, obs_v, exp_v);
      end
      if (!bus4.is_zero_o[2]) low2++;
      if (bus4.is_zero_o[3] !== 1'b1 || bus4.is_zero_o[1:0] !== 2'b11) low_other++;
    end
    checks++;
    if (low2 != 3 || low_other != 0) begin
      failures++;
      $display("FAIL countdown_window got low=%0d other=%0d expected low=3 other=0",
               low2, low_other);
    end
  endtask

  task automatic test_max_merge();
    int low_a = 0;
    int low_b = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 0)      step(1'b1, 1'b1, 0, 10, 1'b0, 0, 1'b0);
      else if (c == 5) step(1'b1, 1'b1, 0, 2, 1'b0, 0, 1'b0);
      else             step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      exp_v = exp_q.pop_front();
      obs_v = {bus4.all_zero_o, bus4.is_zero_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL max_merge_short cyc=%0d got=%b expected=%b", c, obs_v, exp_v);
      end
      if (!bus4.is_zero_o[0]) low_a++;
    end
    for (int c = 0; c < 14; c++) begin
      if (c == 0)      step(1'b1, 1'b1, 0, 5, 1'b0, 0, 1'b0);
      else if (c == 3) step(1'b1, 1'b1, 0, 8, 1'b0, 0, 1'b0);
      else             step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      exp_v = exp_q.pop_front();
      obs_v = {bus4.all_zero_o, bus4.is_zero_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL max_merge_long cyc=%0d got=%b expected=%b", c, obs_v, exp_v);
      end
      if (!bus4.is_zero_o[0]) low_b++;
    end
    checks++;
    if (low_a != 10 || low_b != 11) begin
      failures++;
      $display("FAIL max_merge_window got=%0d,%0d expected=10,11", low_a, low_b);
    end
  endtask

  task automatic test_simultaneous();
    int low_all;
    int low_b1;
    int low_b0;
    for (int r = 0; r < 2; r++) begin
      low_all = 0;
      low_b1  = 0;
      low_b0  = 0;
      for (int c = 0; c < 12; c++) begin
        if (c == 0) step(1'b1, 1'b1, 1, (r == 0) ? 5 : 9, 1'b1, 7, 1'b0);
        else        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        exp_v = exp_q.pop_front();
        obs_v = {bus4.all_zero_o, bus4.is_zero_o};
        checks++;
        if (obs_v !== exp_v) begin
          failures++;
          $display("FAIL simultaneous r=%0d cyc=%0d got=%b expected=%b", r, c, obs_v, exp_v);
        end
        if (!bus4.all_zero_o)   low_all++;
        if (!bus4.is_zero_o[1]) low_b1++;
        if (!bus4.is_zero_o[0]) low_b0++;
      end
      checks++;
      if (low_all != ((r == 0) ? 7 : 9) || low_b1 != ((r == 0) ? 7 : 9) || low_b0 != 7) begin
        failures++;
        $display("FAIL simultaneous_window r=%0d got all=%0d b1=%0d b0=%0d", r, low_all, low_b1, low_b0);
      end
    end
  endtask

  task automatic test_hold();
    int low_a = 0;
    int low_b = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0)                step(1'b1, 1'b1, 3, 4, 1'b0, 0, 1'b0);
      else if (c == 2 || c == 3) step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1);
      else                       step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      exp_v = exp_q.pop_front();
      obs_v = {bus4.all_zero_o, bus4.is_zero_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL hold_extend cyc=%0d got=%b expected=%b", c, obs_v, exp_v);
      end
      if (!bus4.is_zero_o[3]) low_a++;
    end
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      step(1'b1, 1'b1, 3, 4, 1'b0, 0, 1'b0);
      else if (c == 2) step(1'b1, 1'b1, 3, 5, 1'b0, 0, 1'b1);
      else             step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      exp_v = exp_q.pop_front();
      obs_v = {bus4.all_zero_o, bus4.is_zero_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL hold_load cyc=%0d got=%b expected=%b", c, obs_v, exp_v);
      end
      if (!bus4.is_zero_o[3]) low_b++;
    end
    checks++;
    if (low_a != 6 || low_b != 7) begin
      failures++;
      $display("FAIL hold_window got=%0d,%0d expected=6,7", low_a, low_b);
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] exp3_q [$];
    logic [3:0] e3;
    logic [3:0] o3;
    for (int c = 0; c < 5; c++) begin
      bus3.load_valid_i = (c == 0 || c == 2);
      bus3.load_bank_i  = (c == 0) ? 2'd3 : 2'd2;
      bus3.load_value_i = (c == 0) ? CW'(6) : CW'(2);
      case (c)
        0, 1:    exp3_q.push_back(4'b1111);
        2, 3:    exp3_q.push_back(4'b0011);
        default: exp3_q.push_back(4'b1111);
      endcase
      @(posedge clk);
      #1;
      e3 = exp3_q.pop_front();
      o3 = {bus3.all_zero_o, bus3.is_zero_o};
      checks++;
      if (o3 !== e3) begin
        failures++;
        $display("FAIL out_of_range cyc=%0d got=%b expected=%b", c, o3, e3);
      end
    end
    bus3.load_valid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic rst, lv, al, hold;
    int bank, val, av;
    for (int c = 0; c < 300; c++) begin
      rst  = ($urandom_range(0, 99) != 0);
      lv   = ($urandom_range(0, 1) == 1);
      bank = $urandom_range(0, NB - 1);
      val  = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 12);
      al   = ($urandom_range(0, 9) == 0);
      av   = $urandom_range(0, 15);
      hold = ($urandom_range(0, 3) == 0);
      step(rst, lv, bank, val, al, av, hold);
      exp_v = exp_q.pop_front();
      obs_v = {bus4.all_zero_o, bus4.is_zero_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b expected=%b", c, obs_v, exp_v);
      end
    end
  endtask

`ifdef SAL_TIMING_CNTR_EARLY_EN
  task automatic test_early();
    logic [NB-1:0] e;
    logic [NB-1:0] o;
    int n = 0;
    while (early_exp_q.size() > 0) begin
      e = early_exp_q.pop_front();
      o = early_obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL early idx=%0d got=%b expected=%b", n, o, e);
      end
      n++;
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    bus4.load_valid_i = 1'b0; bus4.load_bank_i = '0; bus4.load_value_i = '0;
    bus4.all_load_i = 1'b0;   bus4.all_value_i = '0; bus4.hold_i = 1'b0;
    bus3.load_valid_i = 1'b0; bus3.load_bank_i = '0; bus3.load_value_i = '0;
    bus3.all_load_i = 1'b0;   bus3.all_value_i = '0; bus3.hold_i = 1'b0;
    for (int b = 0; b < NB; b++) m_cntr[b] = '0;

    test_reset();
    test_countdown();
    test_max_merge();
    test_simultaneous();
    test_hold();
    test_out_of_range();
    test_back_to_back();
`ifdef SAL_TIMING_CNTR_EARLY_EN
    test_early();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time ceiling so a stuck bench still terminates.
  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sal_bank_timing_cntr.md
# sal_bank_timing_cntr

Per-bank array of saturating down-counters that enforces DRAM timing constraints (tRCD, tRP, tRAS, tWR, tRFC, ...) in the DDR2 controller's scheduler. Each bank owns one counter that is loaded with a delay when a command is issued and counts down to zero. A bank may accept its next constrained command only while its `is_zero_o` bit is high. Unlike a single-counter timer, loads merge by maximum so a shorter constraint never shortens a longer pending one. A broadcast load and a global hold are also provided.

## Interface
- `CNTR_WIDTH`, default 5: counter and load-value width in bits.
- `NUM_BANKS`, default 4: number of independent bank counters, 1..16.
- `BANK_W`, derived: `$clog2(NUM_BANKS)`, forced to 1 when `NUM_BANKS`==1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `load_valid_i`  in  1  per-bank load strobe.
- `load_bank_i`  in  `BANK_W`  target bank for the per-bank load.
- `load_value_i`  in  `CNTR_WIDTH`  per-bank delay in cycles.
- `all_load_i`  in  1  broadcast load strobe to every bank (e.g. REFRESH → tRFC).
- `all_value_i`  in  `CNTR_WIDTH`  broadcast delay in cycles.
- `hold_i`  in  1  freezes decrement of all counters for this cycle.
- `is_zero_o`  out  `NUM_BANKS`  bit b high when counter b == 0; registered.
- `all_zero_o`  out  1  AND of all `is_zero_o` bits; registered.
- `is_zero_n_o`  out  `NUM_BANKS`  present only with `SAL_TIMING_CNTR_EARLY_EN`; see Configuration.

## Operation
- Per bank b, per cycle:
  - dec = cntr[b]-1 if cntr[b]!=0 and !`hold_i`; otherwise dec = cntr[b]. The counter never wraps below 0.
  - cand_p = `load_value_i` if `load_valid_i` and `load_bank_i`==b; otherwise 0.
  - cand_a = `all_value_i` if `all_load_i`; otherwise 0.
  - cntr_n[b] = max(dec, cand_p, cand_a). All comparisons are unsigned, `CNTR_WIDTH` wide.
- A load value of 0 has no effect.
- A load smaller than the remaining count is absorbed: the counter keeps decrementing from its current value.
- A per-bank load and a broadcast load in the same cycle both apply. The target bank takes the larger of the two.
- A `load_bank_i` value ≥ `NUM_BANKS` is ignored. No counter changes because of it.
- `hold_i` does not block loads. Under hold, a load still merges by max against the undecremented value.
- `is_zero_o[b]` = (cntr[b]==0) and `all_zero_o` = &(cntr==0). Both are driven from registers. There is no combinational path from any input to these outputs.

## Timing
- Reset (`rst_n` low at a clk edge): all counters become 0. `is_zero_o` becomes all-ones and `all_zero_o` becomes 1 on the next cycle.
- Reset applied mid-count clears every counter regardless of `load_valid_i`, `all_load_i` or `hold_i` in that cycle.
- Load latency:
  - A load of V sampled at edge k gives cntr==V after edge k, so `is_zero_o[b]` goes low in cycle k+1.
  - With no hold, the counter reaches 0 after edge k+V, so `is_zero_o[b]` is high again from cycle k+V+1.
  - The bit is therefore low for exactly V cycles.
- Each cycle of `hold_i` asserted extends that low window by one cycle.
- Maximum delay is 2^`CNTR_WIDTH`-1. The counter saturates at 0 and has no upper overflow because loads only replace via max.

## Configuration
- `SAL_TIMING_CNTR_EARLY_EN` defined:
  - Adds output `is_zero_n_o[b]` = (cntr_n[b]==0), which is combinational and one cycle earlier than `is_zero_o`.
  - It depends combinationally on the load inputs and `hold_i` and must be treated as a critical path.
  - When `rst_n` is low, it reads all-ones.
- Undefined: the port is absent and only registered outputs exist. Registered behaviour is identical in both builds.

## Test plan
- Reset: drive counters nonzero, assert `rst_n`=0 for one edge → `is_zero_o`=4'b1111 and `all_zero_o`=1 the next cycle.
- Basic countdown: per-bank load bank 2, value 3 at edge k → `is_zero_o[2]` low in cycles k+1..k+3, high at k+4; other banks stay high.
- Max merge: load bank 0 with 10; 4 cycles later (cntr=6) load bank 0 with 2 → counter continues 5,4,...; zero reached 10 cycles after the first load. Then load 8 while at 3 → counter becomes 8.
- Simultaneous loads: per-bank load bank 1 with 5 plus broadcast 7 in the same cycle → all banks at 7; `all_zero_o` low for 7 cycles. Repeat with per-bank 9 → bank 1 at 9, others at 7.
- Hold: load bank 3 with 4, assert `hold_i` for 2 cycles mid-count → low window = 6 cycles. Load 5 during hold while cntr=3 → cntr=5.
- Out-of-range and early output: `NUM_BANKS`=3, `load_bank_i`=3 with value 6 → no counter changes. With `SAL_TIMING_CNTR_EARLY_EN`, `is_zero_n_o[b]` equals `is_zero_o[b]` delayed backward by one cycle for all prior scenarios.
